spd_cond: RTL

SPD_COND -- requirements
Module: spd_cond

---
 rtl/spd_cond_pkg.sv | 26 ++
 rtl/spd_cond_ch.sv | 138 +++++++++++++
 rtl/spd_cond.sv | 78 +++++++
 3 files changed

// File: rtl/spd_cond_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spd_cond_pkg
//  Description : Shared types and default parameter constants for the motor
//                speed conditioner (channel state enum, default sizing).
//  Revision    : 1.0 - initial release
// ============================================================================
package spd_cond_pkg;

    // Per-channel protection state
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FAULT = 2'd1,
        ST_LOCK  = 2'd2
    } ch_state_t;

    localparam int c_def_nch       = 2;
    localparam int c_def_w         = 12;
    localparam int c_def_depth     = 1;
    localparam int c_def_slew      = 64;
    localparam int c_def_ovr_cnt   = 4;
    localparam int c_def_retry_cyc = 1024;
    localparam int c_def_max_retry = 3;

endpackage
`default_nettype wire

// File: rtl/spd_cond_ch.sv
`default_nettype none
// ============================================================================
//  Module      : spd_cond_ch
//  Description : One motor channel: slew-rate limiter with symmetric
//                saturation, over-current persistence filter and a
//                RUN/FAULT/LOCK protection state machine.
//  Revision    : 1.0 - initial release
// ============================================================================
module spd_cond_ch
    import spd_cond_pkg::*;
#(
    parameter int W         = c_def_w,
    parameter int SLEW      = c_def_slew,
    parameter int OVR_CNT   = c_def_ovr_cnt,
    parameter int RETRY_CYC = c_def_retry_cyc,
    parameter int MAX_RETRY = c_def_max_retry
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_vld,
    input  logic [W-1:0] i_tgt,
    input  logic         i_ovr,
    output logic [W-1:0] o_spd,
    output logic         o_fault,
    output logic         o_lock
);

    localparam int c_cw = $clog2(OVR_CNT + 1);
    localparam int c_tw = $clog2(RETRY_CYC + 1);
    localparam int c_rw = $clog2(MAX_RETRY + 1);
    localparam logic signed [W:0] c_max  = (W+1)'(2**(W-1) - 1);
    localparam logic signed [W:0] c_slew = (W+1)'(SLEW);

    ch_state_t               r_state, w_state_nx;
    logic [c_cw-1:0]         r_cnt, w_cnt_nx;
    logic [c_tw-1:0]         r_tmr, w_tmr_nx;
    logic [c_rw-1:0]         r_trips, w_trips_nx;
    logic signed [W-1:0]     r_cur, w_cur_nx;
    logic [W-1:0]            r_out, w_out_nx;
    logic signed [W:0]       w_tgt, w_cur_ext, w_diff, w_step;
    logic                    w_trip;

    // Slew limiter: clamp the target to the symmetric range, then step toward it
    always_comb begin
        w_tgt     = {i_tgt[W-1], i_tgt};
        w_cur_ext = {r_cur[W-1], r_cur};
        if (w_tgt < -c_max) begin
            w_tgt = -c_max;
        end
        w_diff = w_tgt - w_cur_ext;
        if (w_diff > c_slew) begin
            w_step = w_cur_ext + c_slew;
        end else if (w_diff < -c_slew) begin
            w_step = w_cur_ext - c_slew;
        end else begin
            w_step = w_tgt;
        end
        if (w_step > c_max) begin
            w_step = c_max;
        end else if (w_step < -c_max) begin
            w_step = -c_max;
        end
    end

    // Protection FSM and speed update; a trip overrides a same-cycle update
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_tmr_nx   = r_tmr;
        w_trips_nx = r_trips;
        w_cur_nx   = r_cur;
        w_trip     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (i_ovr) begin
                    if (r_cnt == c_cw'(OVR_CNT - 1)) begin
                        w_trip     = 1'b1;
                        w_trips_nx = r_trips + 1'b1;
                        w_cnt_nx   = '0;
                        w_tmr_nx   = '0;
                        w_cur_nx   = '0;
                        w_state_nx = (w_trips_nx == c_rw'(MAX_RETRY)) ? ST_LOCK : ST_FAULT;
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end else begin
                    w_cnt_nx = '0;
                end
                if (i_vld && !w_trip) begin
                    w_cur_nx = W'(w_step);
                end
            end
            ST_FAULT: begin
                w_cur_nx = '0;
                w_cnt_nx = '0;
                if (r_tmr == c_tw'(RETRY_CYC - 1)) begin
                    w_state_nx = ST_RUN;
                    w_tmr_nx   = '0;
                end else begin
                    w_tmr_nx = r_tmr + 1'b1;
                end
            end
            ST_LOCK: begin
                w_cur_nx = '0;
                w_cnt_nx = '0;
            end
            default: begin
                w_state_nx = ST_RUN;
            end
        endcase
        w_out_nx = i_vld ? w_cur_nx : r_out;
    end

    // State, counters, current speed and published output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_tmr   <= '0;
            r_trips <= '0;
            r_cur   <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_tmr   <= w_tmr_nx;
            r_trips <= w_trips_nx;
            r_cur   <= w_cur_nx;
            r_out   <= w_out_nx;
        end
    end

    assign o_spd   = r_out;
    assign o_fault = (r_state != ST_RUN);
    assign o_lock  = (r_state == ST_LOCK);

endmodule
`default_nettype wire

// File: rtl/spd_cond.sv
`default_nettype none
// ============================================================================
//  Module      : spd_cond
//  Description : Multi-channel motor speed conditioner: input register
//                pipeline followed by NCH independent slew-limited channels
//                with over-current trip, retry and lockout.
//  Revision    : 1.0 - initial release
// ============================================================================
module spd_cond
    import spd_cond_pkg::*;
#(
    parameter int NCH       = c_def_nch,
    parameter int W         = c_def_w,
    parameter int DEPTH     = c_def_depth,
    parameter int SLEW      = c_def_slew,
    parameter int OVR_CNT   = c_def_ovr_cnt,
    parameter int RETRY_CYC = c_def_retry_cyc,
    parameter int MAX_RETRY = c_def_max_retry
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH*W-1:0] spd_in,
    input  logic             in_vld,
    input  logic [NCH-1:0]   ovr_i,
    output logic [NCH*W-1:0] spd_out,
    output logic             out_vld,
    output logic [NCH-1:0]   fault,
    output logic [NCH-1:0]   lock
);

    logic [NCH*W-1:0] r_pipe_dat [DEPTH];
    logic [DEPTH-1:0] r_pipe_vld;
    logic             r_out_vld;

    // Input pipeline; valid travels with its data, out_vld aligns with channel outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe_dat[i] <= '0;
            end
            r_pipe_vld <= '0;
            r_out_vld  <= 1'b0;
        end else begin
            r_pipe_dat[0] <= spd_in;
            r_pipe_vld[0] <= in_vld;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe_dat[i] <= r_pipe_dat[i-1];
                r_pipe_vld[i] <= r_pipe_vld[i-1];
            end
            r_out_vld <= r_pipe_vld[DEPTH-1];
        end
    end

    assign out_vld = r_out_vld;

    generate
        for (genvar k = 0; k < NCH; k++) begin : g_ch
            spd_cond_ch #(
                .W         (W),
                .SLEW      (SLEW),
                .OVR_CNT   (OVR_CNT),
                .RETRY_CYC (RETRY_CYC),
                .MAX_RETRY (MAX_RETRY)
            ) u_ch (
                .clk     (clk),
                .rst     (rst),
                .i_vld   (r_pipe_vld[DEPTH-1]),
                .i_tgt   (r_pipe_dat[DEPTH-1][k*W +: W]),
                .i_ovr   (ovr_i[k]),
                .o_spd   (spd_out[k*W +: W]),
                .o_fault (fault[k]),
                .o_lock  (lock[k])
            );
        end
    endgenerate

endmodule
`default_nettype wire
